// File: rtl/input_port_buffer.sv
// input_port_buffer: router input FIFO that presents its head flit and that flit's XY-route request code to the arbiter.
module input_port_buffer #(
  parameter int FLIT_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int DEPTH      = 4,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0,
  parameter int N_REGISTER = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [FLIT_W-1:0]          in_flit,
  output logic                       in_ready,
  input  logic                       grant,
  output logic [FLIT_W-1:0]          out_flit,
  output logic                       out_valid,
  output logic [N_REGISTER-1:0]      request,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [ADDR_W-1:0] CX = CUR_X[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] CY = CUR_Y[ADDR_W-1:0];
  localparam logic [N_REGISTER-1:0] R_L = N_REGISTER'(0);
  localparam logic [N_REGISTER-1:0] R_N = N_REGISTER'(1);
  localparam logic [N_REGISTER-1:0] R_E = N_REGISTER'(2);
  localparam logic [N_REGISTER-1:0] R_S = N_REGISTER'(3);
  localparam logic [N_REGISTER-1:0] R_W = N_REGISTER'(4);
  localparam logic [N_REGISTER-1:0] R_NONE = N_REGISTER'(7);
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop;
  logic [FLIT_W-1:0] head;
  logic [ADDR_W-1:0] dx, dy;
  logic [N_REGISTER-1:0] route;
  assign in_ready  = cnt_q != CW'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign count     = cnt_q;
  assign push      = in_valid & in_ready;
  assign pop       = grant & out_valid;
  assign head      = mem_q[rd_q];
  assign dx        = head[FLIT_W-1 -: ADDR_W];
  assign dy        = head[FLIT_W-1-ADDR_W -: ADDR_W];
  // Empty output reads as zero so stale storage never leaks onto the crossbar.
  assign out_flit  = out_valid ? head : '0;
  assign request   = out_valid ? route : R_NONE;
  always_comb begin
    route = dx > CX ? R_E :
            dx < CX ? R_W :
            dy > CY ? R_N :
            dy < CY ? R_S : R_L;
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_flit;
  end
endmodule

// File: tb/tb_input_port_buffer.sv
// tb_input_port_buffer: directed vector and corner-case checks for input_port_buffer at router (1,1).
module tb_input_port_buffer;
  logic clk = 0, rst = 1, in_valid = 0, grant = 0, in_ready, out_valid;
  logic [15:0] in_flit = '0, out_flit;
  logic [2:0] request;
  logic [2:0] count;
  int n_chk = 0, n_fail = 0;

  input_port_buffer #(.FLIT_W(16), .ADDR_W(2), .DEPTH(4), .CUR_X(1), .CUR_Y(1), .N_REGISTER(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .grant(grant), .out_flit(out_flit), .out_valid(out_valid), .request(request), .count(count));

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [15:0] f; logic g;
    int cnt; int ov; int req; int of;
  } vec_t;
  vec_t tab[7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] f, input logic g);
    in_valid = v; in_flit = f; grant = g;
    @(negedge clk);
  endtask

  task automatic chk_state(input string name, input int cnt, input int ov, input int rdy, input int req, input int of);
    chk({name, ".count"}, int'(count), cnt);
    chk({name, ".out_valid"}, int'(out_valid), ov);
    chk({name, ".in_ready"}, int'(in_ready), rdy);
    chk({name, ".request"}, int'(request), req);
    chk({name, ".out_flit"}, int'(out_flit), of);
  endtask

  initial begin
    // dest X in [15:14], dest Y in [13:12]; router sits at (1,1)
    tab[0] = '{1'b1, 16'h9001, 1'b0, 1, 1, 2, 16'h9001}; // (2,1) E
    tab[1] = '{1'b1, 16'h3002, 1'b1, 1, 1, 4, 16'h3002}; // (0,3) W
    tab[2] = '{1'b1, 16'h7003, 1'b1, 1, 1, 1, 16'h7003}; // (1,3) N
    tab[3] = '{1'b1, 16'h4004, 1'b1, 1, 1, 3, 16'h4004}; // (1,0) S
    tab[4] = '{1'b1, 16'h5005, 1'b1, 1, 1, 0, 16'h5005}; // (1,1) L
    tab[5] = '{1'b0, 16'h0000, 1'b1, 0, 0, 7, 16'h0000}; // last pop
    tab[6] = '{1'b0, 16'h0000, 1'b1, 0, 0, 7, 16'h0000}; // grant while empty

    #1 chk_state("reset", 0, 0, 1, 7, 0);
    @(negedge clk) rst = 0;

    for (int i = 0; i < 7; i++) begin
      step(tab[i].v, tab[i].f, tab[i].g);
      chk_state($sformatf("vec%0d", i), tab[i].cnt, tab[i].ov, 1, tab[i].req, tab[i].of);
    end

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'h9100 + 16'(i), 1'b0);
      chk_state($sformatf("fill%0d", i), i + 1, 1, i < 3 ? 1 : 0, 2, 16'h9100);
    end
    step(1'b1, 16'hBEEF, 1'b0);
    chk_state("full_drop", 4, 1, 0, 2, 16'h9100);
    step(1'b1, 16'hBEEF, 1'b1);
    chk_state("full_push_pop", 3, 1, 1, 2, 16'h9101);
    step(1'b0, 16'hBEEF, 1'b1);
    chk_state("drain1", 2, 1, 1, 2, 16'h9102);
    step(1'b0, 16'hBEEF, 1'b1);
    chk_state("drain2", 1, 1, 1, 2, 16'h9103);
    step(1'b0, 16'hBEEF, 1'b1);
    chk_state("drain3", 0, 0, 1, 7, 0);

    step(1'b1, 16'h5000, 1'b0);
    chk_state("wrap_prime", 1, 1, 1, 0, 16'h5000);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 16'h5000 + 16'(i), 1'b1);
      chk_state($sformatf("wrap%0d", i), 1, 1, 1, 0, 16'h5000 + i);
    end

    step(1'b1, 16'hA001, 1'b0);
    step(1'b1, 16'hA002, 1'b0);
    in_valid = 0; grant = 0;
    chk({"pre_rst.count"}, int'(count), 3);
    #2 rst = 1;
    #1 chk_state("async_rst", 0, 0, 1, 7, 0);
    #1 rst = 0;
    @(negedge clk);
    chk_state("post_rst", 0, 0, 1, 7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
